pipe_ctrl: RTL

//  Pipeline sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB). Owns the per-stage enables

---
 rtl/pipe_ctrl_if.sv | 42 ++++
 rtl/pipe_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard/status inputs from the datapath and stage-control outputs of the pipeline sequencer.
// slave = sequencer side, master = datapath side.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs2;
    logic             ex_valid;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             br_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             halt_req;

    logic             if_en;
    logic             id_en;
    logic             ex_en;
    logic             mem_en;
    logic             wb_en;
    logic             id_flush;
    logic             ex_bubble;
    logic             pc_redirect;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  id_rs1, id_rs2, id_use_rs2, ex_valid, ex_is_load, ex_rd,
               br_taken, mem_req, mem_ready, halt_req,
        output if_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_bubble,
               pc_redirect, halted, mem_err, stall_cnt
    );

    modport master (
        output id_rs1, id_rs2, id_use_rs2, ex_valid, ex_is_load, ex_rd,
               br_taken, mem_req, mem_ready, halt_req,
        input  if_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_bubble,
               pc_redirect, halted, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables, load-use stall, branch flush, memory wait/timeout, debug drain/halt.
// Latency: enables are combinational from state + inputs; state changes on the next rising edge.
// Backpressure: mem_req & !mem_ready freezes every stage; timeout after MEM_TIMEOUT wait cycles is sticky until reset.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int DRAIN_CYC   = 3,
    parameter int CNT_W       = 16
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_MWAIT,
        S_DRAIN,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_q;

    logic mem_stall;
    logic load_use;
    logic stall_inc;

    assign mem_stall = bus.mem_req & ~bus.mem_ready;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = bus.ex_valid & bus.ex_is_load & (bus.ex_rd != 5'd0) &
                      ((bus.ex_rd == bus.id_rs1) |
                       (bus.id_use_rs2 & (bus.ex_rd == bus.id_rs2)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wait_q  <= 8'd0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wait_d          = wait_q;
        drain_d         = drain_q;
        bus.if_en       = 1'b0;
        bus.id_en       = 1'b0;
        bus.ex_en       = 1'b0;
        bus.mem_en      = 1'b0;
        bus.wb_en       = 1'b0;
        bus.id_flush    = 1'b0;
        bus.ex_bubble   = 1'b0;
        bus.pc_redirect = 1'b0;
        bus.halted      = 1'b0;
        bus.mem_err     = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end

            S_RUN: begin
                if (mem_stall) begin
                    state_d = S_MWAIT;
                    wait_d  = 8'd1;
                end else if (bus.br_taken) begin
                    // Redirect squashes both younger slots (IF->ID and ID->EX).
                    bus.if_en       = 1'b1;
                    bus.id_en       = 1'b1;
                    bus.ex_en       = 1'b1;
                    bus.mem_en      = 1'b1;
                    bus.wb_en       = 1'b1;
                    bus.pc_redirect = 1'b1;
                    bus.id_flush    = 1'b1;
                    bus.ex_bubble   = 1'b1;
                end else if (load_use) begin
                    bus.ex_en     = 1'b1;
                    bus.mem_en    = 1'b1;
                    bus.wb_en     = 1'b1;
                    bus.ex_bubble = 1'b1;
                end else if (bus.halt_req) begin
                    bus.id_en    = 1'b1;
                    bus.ex_en    = 1'b1;
                    bus.mem_en   = 1'b1;
                    bus.wb_en    = 1'b1;
                    bus.id_flush = 1'b1;
                    state_d      = S_DRAIN;
                    drain_d      = DW'(DRAIN_CYC - 1);
                end else begin
                    bus.if_en  = 1'b1;
                    bus.id_en  = 1'b1;
                    bus.ex_en  = 1'b1;
                    bus.mem_en = 1'b1;
                    bus.wb_en  = 1'b1;
                end
            end

            S_MWAIT: begin
                if (bus.mem_ready) begin
                    bus.if_en  = 1'b1;
                    bus.id_en  = 1'b1;
                    bus.ex_en  = 1'b1;
                    bus.mem_en = 1'b1;
                    bus.wb_en  = 1'b1;
                    state_d    = S_RUN;
                    wait_d     = 8'd0;
                end else if (wait_q == 8'(MEM_TIMEOUT)) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_DRAIN: begin
                // A stalled memory access freezes the drain; the countdown resumes afterwards.
                if (!mem_stall) begin
                    bus.id_flush = 1'b1;
                    bus.ex_en    = 1'b1;
                    bus.mem_en   = 1'b1;
                    bus.wb_en    = 1'b1;
                    if (drain_q == '0) begin
                        state_d = S_HALTED;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
            end

            S_HALTED: begin
                bus.halted = 1'b1;
                if (!bus.halt_req) begin
                    state_d = S_RUN;
                end
            end

            S_ERROR: begin
                bus.mem_err = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stall_inc = ((state_q == S_RUN) || (state_q == S_MWAIT)) && !bus.if_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_q;
endmodule
